// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, active qualifiers, sync pulses and
// line/frame strobes, started and stopped only on frame boundaries by tg_enable.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        pxl_clk,
    input  logic        pxl_rst_n,
    input  logic        tg_enable,
    output logic [31:0] horz_res,
    output logic [31:0] vert_res,
    output logic [31:0] horz_cnt,
    output logic [31:0] vert_cnt,
    output logic        horz_active,
    output logic        vert_active,
    output logic        frame_active,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    // S_ARM gives the one-cycle start latency out of IDLE without touching the raster.
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_horz_cnt;
    logic [31:0] r_vert_cnt;
    logic [31:0] w_h_nxt;
    logic [31:0] w_v_nxt;
    logic        w_h_wrap;
    logic        w_frame_end;
    logic        w_count;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        r_horz_active;
    logic        r_vert_active;
    logic        r_frame_active;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_line_start;
    logic        r_frame_start;
    logic        r_running;

    always_comb begin
        w_h_wrap    = (r_horz_cnt == 32'(H_TOTAL - 1));
        w_frame_end = w_h_wrap && (r_vert_cnt == 32'(V_TOTAL - 1));
        w_state_nxt = r_state;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
        case (r_state)
            S_IDLE:  if (tg_enable) w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_RUN;
            default: begin
                if (w_frame_end) begin
                    w_state_nxt = tg_enable ? S_RUN : S_IDLE;
                end else begin
                    w_state_nxt = tg_enable ? S_RUN : S_DRAIN;
                end
                if (w_state_nxt != S_IDLE) begin
                    if (w_h_wrap) begin
                        w_h_nxt = '0;
                        w_v_nxt = (r_vert_cnt == 32'(V_TOTAL - 1)) ? '0 : r_vert_cnt + 32'd1;
                    end else begin
                        w_h_nxt = r_horz_cnt + 32'd1;
                        w_v_nxt = r_vert_cnt;
                    end
                end
            end
        endcase
        // Decode from the next counter values so registered flags line up with the counters.
        w_count = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
        w_h_act = w_count && (w_h_nxt < H_ACTIVE);
        w_v_act = w_count && (w_v_nxt < V_ACTIVE);
        w_hs_on = w_count && (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
        w_vs_on = w_count && (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
    end

    always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
        if (!pxl_rst_n) begin
            r_state        <= S_IDLE;
            r_horz_cnt     <= '0;
            r_vert_cnt     <= '0;
            r_horz_active  <= 1'b0;
            r_vert_active  <= 1'b0;
            r_frame_active <= 1'b0;
            r_hsync        <= ~HSYNC_POL;
            r_vsync        <= ~VSYNC_POL;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_horz_cnt     <= w_h_nxt;
            r_vert_cnt     <= w_v_nxt;
            r_horz_active  <= w_h_act;
            r_vert_active  <= w_v_act;
            r_frame_active <= w_h_act && w_v_act;
            r_hsync        <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync        <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
            r_line_start   <= w_count && (w_h_nxt == '0);
            r_frame_start  <= w_count && (w_h_nxt == '0) && (w_v_nxt == '0);
            r_running      <= w_count;
        end
    end

    assign horz_res     = 32'(H_ACTIVE);
    assign vert_res     = 32'(V_ACTIVE);
    assign horz_cnt     = r_horz_cnt;
    assign vert_cnt     = r_vert_cnt;
    assign horz_active  = r_horz_active;
    assign vert_active  = r_vert_active;
    assign frame_active = r_frame_active;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign running      = r_running;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the VESA/VGA output path. It sits directly upstream of the test-pattern generator and the pixel source. It produces horizontal and vertical counters, active-region qualifiers (`horz_active`, `vert_active`, `frame_active`), sync pulses and start-of-line/frame strobes in the pixel clock domain. Frames start and stop only on frame boundaries, under control of `tg_enable`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `HSYNC_POL`, 0: asserted level of `hsync`; default active-low
- `VSYNC_POL`, 0: asserted level of `vsync`; default active-low

Ports:
- `pxl_clk` in 1: pixel clock; 25.175 MHz for the defaults
- `pxl_rst_n` in 1: reset; asynchronous assert, active-low; the only reset
- `tg_enable` in 1: run request, level-sensitive
- `horz_res` out 32: constant `H_ACTIVE`
- `vert_res` out 32: constant `V_ACTIVE`
- `horz_cnt` out 32: current pixel index within line
- `vert_cnt` out 32: current line index within frame
- `horz_active` out 1: `horz_cnt` < `H_ACTIVE`
- `vert_active` out 1: `vert_cnt` < `V_ACTIVE`
- `frame_active` out 1: `horz_active` AND `vert_active`
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `line_start` out 1: one-cycle strobe on `horz_cnt`==0
- `frame_start` out 1: one-cycle strobe on `horz_cnt`==0 and `vert_cnt`==0
- `running` out 1: high while in RUN or DRAIN

## Operation
- Derived constants: `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800); `V_TOTAL` = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP` (525).
- Line layout: active [0, `H_ACTIVE`-1], then front porch, then sync, then back porch.
  - hsync is asserted for `horz_cnt` in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1], i.e. [656, 751].
- Frame layout: same structure vertically. vsync is asserted for the whole line for `vert_cnt` in [490, 491].
- Counters:
  - `horz_cnt` increments every cycle in RUN/DRAIN and wraps from `H_TOTAL`-1 to 0.
  - `vert_cnt` increments only on the `horz_cnt` wrap and wraps from `V_TOTAL`-1 to 0.
- State machine:
  - IDLE: counters held at 0; all qualifiers and strobes low; syncs at deasserted level. `tg_enable`=1 -> RUN.
  - RUN: counting. `tg_enable`=0 -> DRAIN.
  - DRAIN: counting continues. At `horz_cnt`=`H_TOTAL`-1 and `vert_cnt`=`V_TOTAL`-1:
    - `tg_enable`=1 -> RUN, with no gap in the raster.
    - `tg_enable`=0 -> IDLE, with counters at 0.
  - DRAIN -> RUN mid-frame when `tg_enable` returns to 1. The raster is unaffected.
- Simultaneous events: at the horizontal wrap, `vert_cnt` updates on the same edge that `horz_cnt` goes to 0.
- Width rule: counters are 32-bit unsigned. Parameters must satisfy `H_TOTAL`, `V_TOTAL` < 2^31.

## Timing
- All outputs are registered; no combinational path from `tg_enable` to any output.
- Every output at edge N is consistent with `horz_cnt`/`vert_cnt` at edge N. Qualifiers and syncs do not lag the counters.
- Start from IDLE: `tg_enable` sampled high at edge N -> `running`=1, `horz_cnt`=0, `vert_cnt`=0, `frame_start`=1, `line_start`=1, `frame_active`=1 after edge N+1.
- Stop: the last RUN/DRAIN cycle is `horz_cnt`=799, `vert_cnt`=524. The following edge enters IDLE.
- Reset values (asynchronous, while `pxl_rst_n`=0):
  - state IDLE;
  - `horz_cnt`=`vert_cnt`=0;
  - `horz_active`=`vert_active`=`frame_active`=0;
  - `line_start`=`frame_start`=`running`=0;
  - `hsync`=~`HSYNC_POL`, `vsync`=~`VSYNC_POL`.
- Reset mid-frame forces the reset values immediately. After release, the block waits in IDLE for `tg_enable`.
- `horz_res`/`vert_res` are constants, valid in and out of reset.

## Test plan
- Reset then `tg_enable`=1 held: first `frame_start` one cycle after enable is sampled. Consecutive `frame_start` pulses exactly 420000 cycles apart; `line_start` every 800 cycles.
- Single line scan: `horz_active` high for exactly 640 cycles. `hsync` low for exactly 96 cycles, starting at `horz_cnt`=656. Then `horz_cnt` wraps 799 -> 0 with `vert_cnt`+1.
- Full frame: `vsync` low for exactly 1600 cycles (lines 490–491). `frame_active` high for exactly 307200 cycles per frame. `vert_active` low for lines 480–524.
- Deassert `tg_enable` at `vert_cnt`=100: frame completes through `horz_cnt`=799/`vert_cnt`=524, then IDLE with `running`=0 and syncs high. Reassert `tg_enable` during DRAIN: no interruption; next `frame_start` lands exactly 420000 cycles after the previous one.
- Assert `pxl_rst_n`=0 asynchronously mid-line at `horz_cnt`=300: all outputs take their reset values before the next clock edge. After release with `tg_enable`=1, the raster restarts at 0/0 with `frame_start`.
- Non-default parameters (`H_ACTIVE`=8, `H_FP`=1, `H_SYNC`=2, `H_BP`=1, `V_ACTIVE`=4, `V_FP`=1, `V_SYNC`=1, `V_BP`=1, `HSYNC_POL`=1): frame period 84 cycles; `hsync` high for `horz_cnt` 9–10.
